// File: rtl/beacon_update_rx_pkg.sv
// Shared definitions for the beacon update receiver: word header codes,
// field positions inside a 134-bit stream word, word indices and FSM states.
package beacon_update_rx_pkg;

    localparam int DATA_W = 134;

    localparam int HDR_MSB = 133;
    localparam int HDR_LSB = 132;
    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_MID   = 2'b11;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    localparam int MAC_MSB = 127;
    localparam int MAC_LSB = 80;
    localparam int DIR_BIT = 79;
    localparam int TB_MSB  = 63;
    localparam int TB_LSB  = 32;
    localparam int ETH_MSB = 31;
    localparam int ETH_LSB = 16;
    localparam int MSG_MSB = 11;
    localparam int MSG_LSB = 8;

    localparam logic [3:0] IDX_CLASS = 4'd2;
    localparam logic [3:0] IDX_CFG   = 4'd6;
    localparam logic [3:0] IDX_MAX   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PASS = 2'd2,
        UPD  = 2'd3
    } state_t;

    function automatic logic [3:0] idx_next(input logic [3:0] idx);
        return (idx == IDX_MAX) ? idx : idx + 4'd1;
    endfunction

endpackage

// File: rtl/beacon_pipe_dly.sv
// Fixed 3-cycle delay line for the word stream; no backpressure. Words tagged as part of the
// current packet can be retro-killed (strobes cleared) while still inside the line.
module beacon_pipe_dly
    import beacon_update_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              valid_wr_i,
    input  logic              tag_i,
    input  logic              clr_tag_i,
    input  logic              kill_i,
    output logic              wr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              valid_wr_o
);

    logic [2:0]        wr_q;
    logic [2:0]        vld_q;
    logic [2:0]        vwr_q;
    logic [1:0]        tag_q;
    logic [1:0]        hit;
    logic [DATA_W-1:0] dat_q [3];

    assign hit = {2{kill_i}} & tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            vld_q <= '0;
            vwr_q <= '0;
            tag_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            wr_q     <= {wr_q[1] & ~hit[1], wr_q[0] & ~hit[0], wr_i};
            vwr_q    <= {vwr_q[1] & ~hit[1], vwr_q[0] & ~hit[0], valid_wr_i};
            vld_q    <= {vld_q[1:0], valid_i};
            // A new packet start means older in-flight words no longer belong to it.
            tag_q    <= {tag_q[0] & ~clr_tag_i, tag_i};
            dat_q[0] <= data_i;
            dat_q[1] <= dat_q[0];
            dat_q[2] <= dat_q[1];
        end
    end

    assign wr_o       = wr_q[2];
    assign data_o     = dat_q[2];
    assign valid_o    = vld_q[2];
    assign valid_wr_o = vwr_q[2];

endmodule

// File: rtl/beacon_update_rx.sv
// Beacon update receiver: consumes update frames addressed to this node and commits their config;
// other traffic is forwarded with 3-cycle latency, no backpressure. Optional counters: BEACON_UPDATE_CNT_EN.
module beacon_update_rx
    import beacon_update_rx_pkg::*;
#(
    parameter logic [15:0] ETH_TYPE   = 16'h88F7,
    parameter logic [3:0]  UPD_TYPE   = 4'hD,
    parameter logic [31:0] TB_DEFAULT = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_data_wr,
    input  logic [133:0] in_data,
    input  logic         in_data_valid,
    input  logic         in_data_valid_wr,
    output logic         out_data_wr,
    output logic [133:0] out_data,
    output logic         out_data_valid,
    output logic         out_data_valid_wr,
    input  logic [47:0]  in_local_mac_id,
    output logic         direction,
    output logic [31:0]  token_bucket_para,
    output logic [47:0]  direct_mac_addr,
    output logic         beacon_update_master
`ifdef BEACON_UPDATE_CNT_EN
    ,
    output logic [31:0]  upd_accept_cnt,
    output logic [31:0]  upd_error_cnt
`endif
);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d, cur_idx;
    logic [1:0]  hdr;
    logic        is_first, is_last, is_match;
    logic        pkt_upd, tag, clr_tag, kill, latch_cfg, commit, upd_err;

    logic [47:0] shd_mac_q;
    logic        shd_dir_q;
    logic [31:0] shd_tb_q;
    logic [47:0] mac_q;
    logic        dir_q;
    logic [31:0] tb_q;
    logic        master_q;
    logic [47:0] cmt_mac;
    logic        cmt_dir;
    logic [31:0] cmt_tb;

    assign hdr      = in_data[HDR_MSB:HDR_LSB];
    assign is_first = in_data_wr && (hdr == HDR_FIRST);
    assign is_last  = in_data_wr && (hdr == HDR_LAST);
    assign is_match = (in_data[MAC_MSB:MAC_LSB] == in_local_mac_id) &&
                      (in_data[ETH_MSB:ETH_LSB] == ETH_TYPE) &&
                      (in_data[MSG_MSB:MSG_LSB] == UPD_TYPE);
    assign cur_idx  = is_first ? 4'd0 : idx_next(idx_q);
    assign idx_d    = in_data_wr ? cur_idx : idx_q;

    // A last word at index 6 commits straight from the bus, before the shadow could capture it.
    assign cmt_mac = (cur_idx == IDX_CFG) ? in_data[MAC_MSB:MAC_LSB] : shd_mac_q;
    assign cmt_dir = (cur_idx == IDX_CFG) ? in_data[DIR_BIT]         : shd_dir_q;
    assign cmt_tb  = (cur_idx == IDX_CFG) ? in_data[TB_MSB:TB_LSB]   : shd_tb_q;

    always_comb begin
        state_d   = state_q;
        tag       = 1'b0;
        clr_tag   = 1'b0;
        kill      = 1'b0;
        latch_cfg = 1'b0;
        commit    = 1'b0;
        upd_err   = 1'b0;
        pkt_upd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_first) begin
                    state_d = HDR;
                    clr_tag = 1'b1;
                    tag     = 1'b1;
                end
            end
            HDR: begin
                if (is_first) begin
                    clr_tag = 1'b1;
                    tag     = 1'b1;
                end else if (in_data_wr) begin
                    tag = 1'b1;
                    if (cur_idx == IDX_CLASS) begin
                        if (is_match) begin
                            // Recall words 0 and 1 that are still in the delay line.
                            pkt_upd = 1'b1;
                            kill    = 1'b1;
                            upd_err = is_last;
                            state_d = is_last ? IDLE : UPD;
                        end else begin
                            state_d = is_last ? IDLE : PASS;
                        end
                    end else if (is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            PASS: begin
                if (is_first) begin
                    state_d = HDR;
                    clr_tag = 1'b1;
                    tag     = 1'b1;
                end else if (is_last) begin
                    state_d = IDLE;
                end
            end
            UPD: begin
                if (is_first) begin
                    state_d = HDR;
                    clr_tag = 1'b1;
                    tag     = 1'b1;
                    upd_err = 1'b1;
                end else begin
                    pkt_upd   = 1'b1;
                    latch_cfg = in_data_wr && (cur_idx == IDX_CFG);
                    if (is_last) begin
                        state_d = IDLE;
                        if ((cur_idx >= IDX_CFG) && in_data_valid && in_data_valid_wr) begin
                            commit = 1'b1;
                        end else begin
                            upd_err = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shd_mac_q <= '0;
            shd_dir_q <= 1'b0;
            shd_tb_q  <= '0;
            mac_q     <= '0;
            dir_q     <= 1'b0;
            tb_q      <= TB_DEFAULT;
            master_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (is_first) begin
                shd_mac_q <= '0;
                shd_dir_q <= 1'b0;
                shd_tb_q  <= '0;
            end else if (latch_cfg) begin
                shd_mac_q <= in_data[MAC_MSB:MAC_LSB];
                shd_dir_q <= in_data[DIR_BIT];
                shd_tb_q  <= in_data[TB_MSB:TB_LSB];
            end
            if (commit) begin
                mac_q    <= cmt_mac;
                dir_q    <= cmt_dir;
                tb_q     <= cmt_tb;
                master_q <= ~master_q;
            end
        end
    end

    beacon_pipe_dly u_dly (
        .clk        (clk),
        .rst        (rst),
        .wr_i       (in_data_wr & ~pkt_upd),
        .data_i     (in_data),
        .valid_i    (in_data_valid),
        .valid_wr_i (in_data_valid_wr & ~pkt_upd),
        .tag_i      (tag),
        .clr_tag_i  (clr_tag),
        .kill_i     (kill),
        .wr_o       (out_data_wr),
        .data_o     (out_data),
        .valid_o    (out_data_valid),
        .valid_wr_o (out_data_valid_wr)
    );

    assign direct_mac_addr      = mac_q;
    assign direction            = dir_q;
    assign token_bucket_para    = tb_q;
    assign beacon_update_master = master_q;

`ifdef BEACON_UPDATE_CNT_EN
    logic [31:0] acc_cnt_q;
    logic [31:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (commit) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if (upd_err) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign upd_accept_cnt = acc_cnt_q;
    assign upd_error_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_beacon_update_rx.sv
// Bench for beacon_update_rx: directed scenarios plus random packets against a packet-level model.
module tb_beacon_update_rx;

    localparam logic [15:0] ETH    = 16'h88F7;
    localparam logic [3:0]  UPT    = 4'hD;
    localparam logic [31:0] TBD    = 32'h5A5A_0001;
    localparam logic [47:0] MY_MAC = 48'h02_11_22_33_44_55;
    localparam int MAXC = 8192;
    localparam int MAXP = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_data_wr, in_data_valid, in_data_valid_wr;
    logic [133:0] in_data;
    logic         out_data_wr, out_data_valid, out_data_valid_wr;
    logic [133:0] out_data;
    logic         direction, beacon_update_master;
    logic [31:0]  token_bucket_para;
    logic [47:0]  direct_mac_addr;
`ifdef BEACON_UPDATE_CNT_EN
    logic [31:0]  upd_accept_cnt, upd_error_cnt;
`endif

    beacon_update_rx #(.TB_DEFAULT(TBD)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_data_wr           (in_data_wr),
        .in_data              (in_data),
        .in_data_valid        (in_data_valid),
        .in_data_valid_wr     (in_data_valid_wr),
        .out_data_wr          (out_data_wr),
        .out_data             (out_data),
        .out_data_valid       (out_data_valid),
        .out_data_valid_wr    (out_data_valid_wr),
        .in_local_mac_id      (MY_MAC),
        .direction            (direction),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .beacon_update_master (beacon_update_master)
`ifdef BEACON_UPDATE_CNT_EN
        ,
        .upd_accept_cnt       (upd_accept_cnt),
        .upd_error_cnt        (upd_error_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Input history per cycle and packet classification.
    logic         h_wr  [MAXC];
    logic         h_v   [MAXC];
    logic         h_vwr [MAXC];
    logic [133:0] h_dat [MAXC];
    int           h_pid [MAXC];
    bit           upd_pkt [MAXP];
    int  cyc = 0;
    int  pid = -1;
    int  cnt = 0;
    bit  active = 1'b0;
    logic [47:0] w6_mac;
    logic        w6_dir;
    logic [31:0] w6_tb;
    logic        e_dir, e_master;
    logic [31:0] e_tb;
    logic [47:0] e_mac;
    logic [31:0] e_acc, e_err;
    int  out_cnt = 0;
    logic [133:0] pw [18];

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] rnd134();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[133:0];
    endfunction

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    task automatic model_step();
        logic [1:0] hdr;
        h_wr[cyc]  = 1'b0;
        h_vwr[cyc] = 1'b0;
        h_v[cyc]   = in_data_valid;
        h_dat[cyc] = in_data;
        h_pid[cyc] = -1;
        if (rst) begin
            for (int k = 1; k <= 2; k++) begin
                if (cyc - k >= 0) begin
                    h_wr[cyc-k]  = 1'b0;
                    h_vwr[cyc-k] = 1'b0;
                end
            end
            active   = 1'b0;
            e_dir    = 1'b0;
            e_tb     = TBD;
            e_mac    = '0;
            e_master = 1'b0;
            e_acc    = '0;
            e_err    = '0;
        end else begin
            h_wr[cyc]  = in_data_wr;
            h_vwr[cyc] = in_data_valid_wr;
            hdr = in_data[133:132];
            if (in_data_wr && hdr == 2'b01) begin
                if (active && upd_pkt[pid]) e_err++;
                pid++;
                upd_pkt[pid] = 1'b0;
                cnt = 0;
                active = 1'b1;
            end else if (in_data_wr && active) begin
                cnt = (cnt < 15) ? cnt + 1 : 15;
            end
            if (active) h_pid[cyc] = pid;
            if (in_data_wr && active) begin
                if (cnt == 2)
                    upd_pkt[pid] = (in_data[127:80] == MY_MAC) && (in_data[31:16] == ETH) &&
                                   (in_data[11:8] == UPT);
                if (cnt == 6) begin
                    w6_mac = in_data[127:80];
                    w6_dir = in_data[79];
                    w6_tb  = in_data[63:32];
                end
                if (hdr == 2'b10) begin
                    if (upd_pkt[pid]) begin
                        if (cnt >= 6 && in_data_valid && in_data_valid_wr) begin
                            e_mac    = w6_mac;
                            e_dir    = w6_dir;
                            e_tb     = w6_tb;
                            e_master = ~e_master;
                            e_acc++;
                        end else begin
                            e_err++;
                        end
                    end
                    active = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        logic exp_wr, exp_vwr, drop;
        int src;
        @(posedge clk);
        model_step();
        #1;
        src = cyc - 2;
        exp_wr  = 1'b0;
        exp_vwr = 1'b0;
        if (src >= 0) begin
            drop    = (h_pid[src] >= 0) && upd_pkt[h_pid[src]];
            exp_wr  = h_wr[src] & ~drop;
            exp_vwr = h_vwr[src] & ~drop;
        end
        chk("out_wr", 134'(out_data_wr), 134'(exp_wr));
        if (exp_wr) chk("out_data", out_data, h_dat[src]);
        chk("out_vwr", 134'(out_data_valid_wr), 134'(exp_vwr));
        if (exp_vwr) chk("out_valid", 134'(out_data_valid), 134'(h_v[src]));
        chk("direction", 134'(direction), 134'(e_dir));
        chk("token_bucket", 134'(token_bucket_para), 134'(e_tb));
        chk("direct_mac", 134'(direct_mac_addr), 134'(e_mac));
        chk("master", 134'(beacon_update_master), 134'(e_master));
`ifdef BEACON_UPDATE_CNT_EN
        chk("accept_cnt", 134'(upd_accept_cnt), 134'(e_acc));
        chk("error_cnt", 134'(upd_error_cnt), 134'(e_err));
`endif
        if (out_data_wr) out_cnt++;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic set_idle();
        in_data_wr       = 1'b0;
        in_data_valid    = 1'b0;
        in_data_valid_wr = 1'b0;
        in_data          = rnd134();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            tick();
        end
    endtask

    task automatic build_pkt(input int n, input logic [47:0] dst, input logic [15:0] eth,
                             input logic [3:0] typ, input logic [47:0] mac6, input logic dir6,
                             input logic [31:0] tb6);
        logic [133:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd134();
            w[133:132] = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
            if (i == 2) begin
                w[127:80] = dst;
                w[31:16]  = eth;
                w[11:8]   = typ;
            end
            if (i == 6) begin
                w[127:80] = mac6;
                w[79]     = dir6;
                w[63:32]  = tb6;
            end
            pw[i] = w;
        end
    endtask

    // Sends pw[0..n_send-1]; idle gaps of gmin..gmax cycles follow each word from index gap_from on.
    task automatic send_words(input int n_send, input int gmin, input int gmax, input int gap_from,
                              input logic lastv);
        int g;
        for (int i = 0; i < n_send; i++) begin
            in_data_wr       = 1'b1;
            in_data          = pw[i];
            in_data_valid_wr = (pw[i][133:132] == 2'b10);
            in_data_valid    = in_data_valid_wr ? lastv : 1'b0;
            tick();
            if (i < n_send - 1 && i >= gap_from) begin
                g = $urandom_range(gmax, gmin);
                idle(g);
            end
        end
    endtask

    initial begin
        int oc, kind, n, sub, ncut;
        logic [47:0] dst;
        logic [15:0] eth;
        logic [3:0]  typ;

        rst = 1'b1;
        set_idle();
        tick();
        tick();
        tick();
        chk("reset_out_wr", 134'(out_data_wr), 134'(1'b0));
        chk("reset_tb", 134'(token_bucket_para), 134'(TBD));
        chk("reset_master", 134'(beacon_update_master), 134'(1'b0));
        chk("reset_mac", 134'(direct_mac_addr), 134'(48'h0));
        rst = 1'b0;
        idle(2);

        // Update to local MAC, 8 words, no gaps.
        build_pkt(8, MY_MAC, ETH, UPT, 48'h0A0B0C0D0E0F, 1'b1, 32'h12345678);
        oc = out_cnt;
        send_words(8, 0, 0, 0, 1'b1);
        chk("upd_master_toggle", 134'(beacon_update_master), 134'(1'b1));
        idle(4);
        chk("upd_no_strobes", 134'(out_cnt - oc), 134'(0));
        chk("upd_mac", 134'(direct_mac_addr), 134'(48'h0A0B0C0D0E0F));
        chk("upd_dir", 134'(direction), 134'(1'b1));
        chk("upd_tb", 134'(token_bucket_para), 134'(32'h12345678));

        // Same packet, wrong destination: forwarded, config unchanged.
        build_pkt(8, MY_MAC ^ 48'h1, ETH, UPT, 48'h112233445566, 1'b0, 32'hDEADBEEF);
        oc = out_cnt;
        send_words(8, 0, 0, 0, 1'b1);
        idle(4);
        chk("mismatch_fwd_cnt", 134'(out_cnt - oc), 134'(8));
        chk("mismatch_cfg", 134'(token_bucket_para), 134'(32'h12345678));

        // Update ending at index 4: no commit.
        build_pkt(5, MY_MAC, ETH, UPT, 48'h0, 1'b0, 32'h0);
        send_words(5, 0, 0, 0, 1'b1);
        idle(3);
        chk("short_upd_master", 134'(beacon_update_master), 134'(1'b1));
`ifdef BEACON_UPDATE_CNT_EN
        chk("short_upd_err", 134'(upd_error_cnt), 134'(32'd1));
`endif

        // Restart at index 5, then a valid update.
        build_pkt(8, MY_MAC, ETH, UPT, 48'hAAAA_BBBB_CCCC, 1'b1, 32'h0BAD_0BAD);
        send_words(5, 0, 0, 0, 1'b1);
        build_pkt(8, MY_MAC, ETH, UPT, 48'h1234_5678_9ABC, 1'b0, 32'hCAFE_F00D);
        send_words(8, 0, 0, 0, 1'b1);
        idle(3);
        chk("restart_master", 134'(beacon_update_master), 134'(1'b0));
        chk("restart_mac", 134'(direct_mac_addr), 134'(48'h1234_5678_9ABC));
        chk("restart_tb", 134'(token_bucket_para), 134'(32'hCAFE_F00D));
`ifdef BEACON_UPDATE_CNT_EN
        chk("restart_acc", 134'(upd_accept_cnt), 134'(32'd2));
        chk("restart_err", 134'(upd_error_cnt), 134'(32'd2));
`endif

        // Pass packet with gaps, then an update back-to-back with gaps after its index-2 word.
        build_pkt(6, MY_MAC ^ 48'h8000, ETH, UPT, 48'h0, 1'b0, 32'h0);
        oc = out_cnt;
        send_words(6, 2, 2, 0, 1'b1);
        build_pkt(9, MY_MAC, ETH, UPT, 48'h0F0E_0D0C_0B0A, 1'b1, 32'h7777_1111);
        send_words(9, 2, 2, 2, 1'b1);
        idle(4);
        chk("gap_pass_cnt", 134'(out_cnt - oc), 134'(6));
        chk("gap_upd_master", 134'(beacon_update_master), 134'(1'b1));
        chk("gap_upd_tb", 134'(token_bucket_para), 134'(32'h7777_1111));

        // Reset in the middle of an update, then a 2-word pass packet.
        build_pkt(8, MY_MAC, ETH, UPT, 48'h5555_6666_7777, 1'b0, 32'h4444_3333);
        send_words(4, 0, 0, 0, 1'b1);
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_tb", 134'(token_bucket_para), 134'(TBD));
        chk("midrst_master", 134'(beacon_update_master), 134'(1'b0));
        build_pkt(2, MY_MAC ^ 48'h2, ETH, UPT, 48'h0, 1'b0, 32'h0);
        oc = out_cnt;
        send_words(2, 0, 0, 0, 1'b1);
        idle(4);
        chk("midrst_pass_cnt", 134'(out_cnt - oc), 134'(2));

        // Random traffic.
        for (int p = 0; p < 80; p++) begin
            kind = $urandom_range(4, 0);
            case (kind)
                0: begin
                    n   = $urandom_range(18, 2);
                    sub = $urandom_range(2, 0);
                    dst = (sub == 0) ? (MY_MAC ^ (48'h1 << $urandom_range(47, 0))) : MY_MAC;
                    eth = (sub == 1) ? (ETH ^ 16'h0100) : ETH;
                    typ = (sub == 2) ? (UPT ^ 4'h1) : UPT;
                    build_pkt(n, dst, eth, typ, rnd48(), 1'($urandom), $urandom());
                    send_words(n, 0, 2, 0, 1'b1);
                end
                1: begin
                    n = $urandom_range(18, 7);
                    build_pkt(n, MY_MAC, ETH, UPT, rnd48(), 1'($urandom), $urandom());
                    send_words(n, 0, 2, 2, 1'b1);
                end
                2: begin
                    n = $urandom_range(6, 3);
                    build_pkt(n, MY_MAC, ETH, UPT, rnd48(), 1'($urandom), $urandom());
                    send_words(n, 0, 1, 2, 1'b1);
                end
                3: begin
                    n = $urandom_range(12, 7);
                    build_pkt(n, MY_MAC, ETH, UPT, rnd48(), 1'($urandom), $urandom());
                    send_words(n, 0, 1, 2, 1'b0);
                end
                default: begin
                    ncut = $urandom_range(7, 1);
                    build_pkt(8, MY_MAC, ETH, UPT, rnd48(), 1'($urandom), $urandom());
                    send_words(ncut, 0, 0, 0, 1'b1);
                end
            endcase
            if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
